exp_mem_engine: RTL

- Avalon-MM master engine that sits directly upstream of the 1024x32 single-port on-chip RAM and is its only client during a job.
- Reads N base words from a source window and computes base^E mod 2^32 for each by square-and-multiply.
- Writes the results to a destination window, then flags done.
- Configured by the CPU through a small Avalon-MM CSR slave.

---
 rtl/exp_mem_engine.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/exp_mem_engine.sv
// exp_mem_engine: Avalon-MM master that reads COUNT words from a source window,
// raises each to the power EXP (mod 2^DW) by square-and-multiply, and writes the
// results to a destination window. Configured through a small CSR slave.
module exp_mem_engine #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [2:0]    s_address,
   input  logic          s_write,
   input  logic          s_read,
   input  logic [31:0]   s_writedata,
   output logic [31:0]   s_readdata,
   output logic [AW-1:0] m_address,
   output logic          m_chipselect,
   output logic          m_write,
   output logic [3:0]    m_byteenable,
   output logic [DW-1:0] m_writedata,
   output logic          m_clken,
   input  logic [DW-1:0] m_readdata,
   output logic          irq
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_MUL  = 3'd3,
      S_WR   = 3'd4
   } state_t;

   state_t        state_q, state_d;

   // CSR state
   logic          ie_q;
   logic          done_q;
   logic [AW-1:0] src_q;
   logic [AW-1:0] dst_q;
   logic [AW:0]   cnt_q;
   logic [31:0]   exp_q;

   // Job datapath
   logic [AW:0]   idx_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] r_q;
   logic [31:0]   e_q;

   logic          busy;
   logic          ctrl_wr;
   logic          start_acc;
   logic          last_elem;
   logic          unused_ok;

   // Reads have no side effects, so the read strobe is not needed.
   assign unused_ok = s_read;

   assign busy      = (state_q != S_IDLE);
   assign ctrl_wr   = s_write && (s_address == 3'd0);
   assign start_acc = ctrl_wr && s_writedata[0] && !busy;
   assign last_elem = ((idx_q + (AW+1)'(1)) == cnt_q);

   assign m_byteenable = 4'hF;
   assign m_clken      = 1'b1;
   assign irq          = done_q & ie_q;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic: RD -> CAP -> MUL* -> WR per element
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_acc && (cnt_q != '0)) state_d = S_RD;
         S_RD:   state_d = S_CAP;
         S_CAP:  state_d = (exp_q != '0) ? S_MUL : S_WR;
         S_MUL:  state_d = ((e_q >> 1) != '0) ? S_MUL : S_WR;
         S_WR:   state_d = last_elem ? S_IDLE : S_RD;
         default: state_d = S_IDLE;
      endcase
   end

   // Bus outputs decoded from the current state; quiet outside RD/WR
   always_comb begin
      m_chipselect = 1'b0;
      m_write      = 1'b0;
      m_address    = '0;
      m_writedata  = '0;
      case (state_q)
         S_RD: begin
            m_chipselect = 1'b1;
            m_address    = src_q + idx_q[AW-1:0];
         end
         S_WR: begin
            m_chipselect = 1'b1;
            m_write      = 1'b1;
            m_address    = dst_q + idx_q[AW-1:0];
            m_writedata  = r_q;
         end
         default: ;
      endcase
   end

   // CSR updates and square-and-multiply datapath
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ie_q   <= 1'b0;
         done_q <= 1'b0;
         src_q  <= '0;
         dst_q  <= '0;
         cnt_q  <= '0;
         exp_q  <= '0;
         idx_q  <= '0;
         b_q    <= '0;
         r_q    <= '0;
         e_q    <= '0;
      end else begin
         if (ctrl_wr) ie_q <= s_writedata[2];
         // Job parameters are frozen while a job runs
         if (s_write && !busy) begin
            case (s_address)
               3'd1: src_q <= s_writedata[AW-1:0];
               3'd2: dst_q <= s_writedata[AW-1:0];
               3'd3: cnt_q <= s_writedata[AW:0];
               3'd4: exp_q <= s_writedata;
               default: ;
            endcase
         end
         if (start_acc) begin
            done_q <= (cnt_q == '0);
            idx_q  <= '0;
         end
         case (state_q)
            S_CAP: begin
               b_q <= m_readdata;
               r_q <= DW'(1);
               e_q <= exp_q;
            end
            S_MUL: begin
               if (e_q[0]) r_q <= r_q * b_q;
               b_q <= b_q * b_q;
               e_q <= e_q >> 1;
            end
            S_WR: begin
               idx_q <= idx_q + (AW+1)'(1);
               if (last_elem) done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Zero-latency CSR read mux
   always_comb begin
      s_readdata = '0;
      case (s_address)
         3'd0: s_readdata = {29'd0, ie_q, done_q, busy};
         3'd1: s_readdata = 32'(src_q);
         3'd2: s_readdata = 32'(dst_q);
         3'd3: s_readdata = 32'(cnt_q);
         3'd4: s_readdata = exp_q;
         default: s_readdata = '0;
      endcase
   end

endmodule
